// File: rtl/stride_generator_pkg.sv
// Shared types for the stride generator/detector pair.
package stride_pkg;

  typedef logic [31:0] value_t;

  typedef enum logic {
    IDLE,
    EMIT
  } gen_state_e;

  typedef enum logic {
    MODE_SINGLE,
    MODE_DOUBLE
  } stride_mode_e;

  // Sign-extend the low w bits of raw to a full value.
  function automatic value_t sext_stride(
    input value_t raw,
    input int     w
  );
    logic signed [31:0] t;
    t = $signed(raw << (32 - w));
    return value_t'(t >>> (32 - w));
  endfunction

endpackage

// File: rtl/stride_generator_if.sv
// Valid/ready value stream from the stride generator.
interface stride_generator_if;
  import stride_pkg::*;

  value_t value;
  logic   valid;
  logic   ready;

  modport master (
    output value,
    output valid,
    input  ready
  );

  modport slave (
    input  value,
    input  valid,
    output ready
  );

endinterface

// File: rtl/stride_generator.sv
// Replays base + alternating signed strides as a valid/ready stream.
// Define STRIDE_GEN_REPEAT_EN to make count_i=0 an unbounded burst.
module stride_generator
  import stride_pkg::*;
#(
  parameter int MAX_STRIDE_WIDTH = 5,
  parameter int COUNT_WIDTH      = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  value_t                      base_i,
  input  logic [COUNT_WIDTH-1:0]      count_i,
  input  logic [MAX_STRIDE_WIDTH-1:0] stride_1_i,
  input  logic                        stride_1_valid_i,
  input  logic [MAX_STRIDE_WIDTH-1:0] stride_2_i,
  input  logic                        stride_2_valid_i,
  input  logic                        abort_i,
  stride_generator_if.master          strm,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);

  gen_state_e             state_q;
  stride_mode_e           mode_q;
  value_t                 value_q;
  value_t                 s1_q;
  value_t                 s2_q;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic                   phase_q;
  logic                   inf_q;
  logic                   done_q;
  logic                   err_q;

  value_t step_d;
  value_t next_d;
  logic   hs_d;
  logic   last_d;

  always_comb begin
    step_d = s1_q;
    if (mode_q == MODE_DOUBLE && phase_q)
      step_d = s2_q;
    next_d = value_q + step_d;
    hs_d   = (state_q == EMIT) && strm.ready;
    last_d = !inf_q && (cnt_q == COUNT_WIDTH'(1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mode_q  <= MODE_SINGLE;
      value_q <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      inf_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i && !abort_i) begin
            if (!stride_1_valid_i) begin
              err_q <= 1'b1;
            end else begin
              value_q <= base_i;
              cnt_q   <= count_i;
              phase_q <= 1'b0;
              inf_q   <= 1'b0;
              s1_q    <= sext_stride(value_t'(stride_1_i), MAX_STRIDE_WIDTH);
              s2_q    <= sext_stride(value_t'(stride_2_i), MAX_STRIDE_WIDTH);
              mode_q  <= stride_2_valid_i ? MODE_DOUBLE : MODE_SINGLE;
              if (count_i == '0) begin
`ifdef STRIDE_GEN_REPEAT_EN
                inf_q   <= 1'b1;
                state_q <= EMIT;
`else
                done_q  <= 1'b1;
`endif
              end else begin
                state_q <= EMIT;
              end
            end
          end
        end
        EMIT: begin
          // Abort wins even over a same-cycle final handshake.
          if (abort_i) begin
            state_q <= IDLE;
          end else if (hs_d) begin
            if (last_d) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              value_q <= next_d;
              if (!inf_q)
                cnt_q <= cnt_q - COUNT_WIDTH'(1);
              phase_q <= ~phase_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign strm.value = value_q;
  assign strm.valid = (state_q == EMIT);
  assign busy_o     = (state_q == EMIT);
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_stride_generator.sv
// Directed bench for stride_generator.
// Covers STRIDE_GEN_REPEAT_EN when that macro is defined.
module tb_stride_generator;
  import stride_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  value_t     base = '0;
  logic [7:0] count = '0;
  logic [4:0] s1 = '0;
  logic       v1 = 1'b0;
  logic [4:0] s2 = '0;
  logic       v2 = 1'b0;
  logic       abort = 1'b0;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  value_t dexp [5] = '{
    32'h0, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFA
  };
  value_t wexp [3] = '{
    32'hFFFFFFFE, 32'h1, 32'h4
  };

  stride_generator_if strm ();

  stride_generator dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .base_i           (base),
    .count_i          (count),
    .stride_1_i       (s1),
    .stride_1_valid_i (v1),
    .stride_2_i       (s2),
    .stride_2_valid_i (v2),
    .abort_i          (abort),
    .strm             (strm.master),
    .busy_o           (busy),
    .done_o           (done),
    .err_o            (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, value_t obs, value_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(string tag, logic dn);
    chk({tag, "_valid"}, 32'(strm.valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'(dn));
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic go(value_t b, logic [7:0] c, logic [4:0] a,
                    logic va, logic [4:0] bb, logic vb);
    base = b; count = c; s1 = a; v1 = va; s2 = bb; v2 = vb;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    strm.ready = 1'b1;
    tick();
    tick();
    chk("rst_value", strm.value, 32'd0);
    chk_idle("rst", 1'b0);
    rst = 1'b0;
    tick();

    // single mode
    go(32'd100, 8'd4, 5'd3, 1'b1, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("single_value", strm.value, value_t'(100 + 3 * i));
      chk("single_valid", 32'(strm.valid), 32'd1);
      chk("single_busy", 32'(busy), 32'd1);
      chk("single_nodone", 32'(done), 32'd0);
      tick();
    end
    chk_idle("single_end", 1'b1);
    tick();
    chk("single_done_once", 32'(done), 32'd0);

    // double mode
    go(32'd0, 8'd5, 5'd2, 1'b1, 5'b11011, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("double_value", strm.value, dexp[i]);
      chk("double_valid", 32'(strm.valid), 32'd1);
      tick();
    end
    chk_idle("double_end", 1'b1);
    tick();

    // backpressure and wrap
    strm.ready = 1'b0;
    go(32'hFFFFFFFE, 8'd3, 5'd3, 1'b1, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      strm.ready = 1'b0;
      chk("bp_value", strm.value, wexp[i]);
      tick();
      chk("bp_hold", strm.value, wexp[i]);
      chk("bp_hold_valid", 32'(strm.valid), 32'd1);
      strm.ready = 1'b1;
      tick();
    end
    chk_idle("bp_end", 1'b1);
    tick();

    // rejected start
    go(32'd7, 8'd3, 5'd1, 1'b0, 5'd1, 1'b1);
    chk("err_pulse", 32'(err), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_valid", 32'(strm.valid), 32'd0);
    chk("err_nodone", 32'(done), 32'd0);
    tick();
    chk("err_once", 32'(err), 32'd0);

`ifndef STRIDE_GEN_REPEAT_EN
    // empty burst
    go(32'd9, 8'd0, 5'd1, 1'b1, 5'd0, 1'b0);
    chk_idle("empty", 1'b1);
    tick();
    chk_idle("empty_after", 1'b0);
`else
    // unbounded burst until abort
    go(32'd10000, 8'd0, 5'b10000, 1'b1, 5'd0, 1'b0);
    for (int i = 0; i < 320; i++) begin
      chk("rep_value", strm.value, value_t'(10000 - 16 * i));
      chk("rep_nodone", 32'(done), 32'd0);
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("rep_abort", 1'b0);
    tick();
    chk("rep_abort_nodone", 32'(done), 32'd0);
`endif

    // abort at third handshake
    go(32'd0, 8'd10, 5'd1, 1'b1, 5'd0, 1'b0);
    tick();
    tick();
    chk("abort_pre_value", strm.value, 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort", 1'b0);
    tick();
    chk("abort_nodone", 32'(done), 32'd0);

    // abort in IDLE blocks start
    abort = 1'b1;
    go(32'd5, 8'd2, 5'd1, 1'b1, 5'd0, 1'b0);
    abort = 1'b0;
    chk_idle("idle_abort", 1'b0);
    tick();

    // reset mid-burst
    go(32'd50, 8'd10, 5'd1, 1'b1, 5'd0, 1'b0);
    tick();
    chk("rst_mid_pre", strm.value, 32'd51);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_value", strm.value, 32'd0);
    chk_idle("rst_mid", 1'b0);
    tick();
    chk("rst_mid_nodone", 32'(done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
